seq_divider_16x8: RTL and testbench
===================================

# seq_divider_16x8

Sequential radix-2 restoring divider: 16-bit unsigned dividend by 8-bit unsigned divisor, producing a 16-bit quotient and 8-bit remainder. It is the inverse-direction companion to the 8x8 multiplier datapath and sits beside it in the arithmetic test harness. It uses a start/ready/done handshake so a bench or controller can check a multiplier product by dividing it back.

## Interface
- N_W, default 16, dividend and quotient width.
- D_W, default 8, divisor and remainder width.
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous, active-low; all state cleared while low.
- start  input  1  request; sampled only when ready=1.
- dividend  input  N_W  unsigned dividend, captured on an accepted start.
- divisor  input  D_W  unsigned divisor, captured on an accepted start.
- ready  output  1  high in IDLE and DONE; block can accept start.
- done  output  1  one-cycle pulse when the result becomes valid.
- quotient  output  N_W  result, held until the next accepted start.
- remainder  output  D_W  result, held until the next accepted start.
- div_by_zero  output  1  set with done when the captured divisor is 0; held like the results.

## Operation
- States: IDLE, CALC, DONE.
  - IDLE --start--> CALC, or --> DONE if divisor==0.
  - CALC --count==N_W-1--> DONE.
  - DONE --start--> CALC, or DONE if divisor==0; otherwise stays in DONE after the done pulse.
- Accept: start=1 and ready=1 at a rising edge. On accept:
  - load the dividend shift register;
  - clear the partial remainder (D_W+1 bits);
  - latch the divisor;
  - count=0;
  - clear div_by_zero.
- CALC step, one per cycle, MSB first:
  - r' = {r[D_W-1:0], dividend msb};
  - if r' >= {1'b0, divisor}, then r = r' - divisor and q bit = 1; else r = r' and q bit = 0;
  - shift the q bit into the quotient LSB.
- The partial remainder is D_W+1 bits wide so the compare never overflows. The final remainder is the low D_W bits and is always less than divisor.
- Divide by zero:
  - no iterations run;
  - quotient = all ones (16'hFFFF), remainder = 0, div_by_zero = 1.
- start while in CALC is ignored; the operation in flight is unaffected.
- DONE counts as idle for handshake purposes: start may be accepted in the same cycle done is high (back-to-back).
- Reset mid-operation aborts the operation with no done pulse.

## Timing
- Reset values: ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, state IDLE, count=0.
- Nonzero divisor:
  - accept at edge T;
  - CALC occupies edges T+1 .. T+N_W (16 cycles);
  - done=1 and results valid during the cycle after edge T+N_W;
  - latency 16 cycles from the accept edge; throughput one result per 17 cycles with back-to-back start.
- Zero divisor: done=1 during the cycle after edge T+1; latency 1.
- ready=0 for exactly the CALC cycles.
- done is high for exactly one cycle per accepted start.
- quotient, remainder and div_by_zero change only at the accept edge (cleared and then accumulated) and at completion. Intermediate CALC values on quotient are not guaranteed; consumers sample only on done.

## Structure
- Shared package div_pkg:
  - state enum (IDLE, CALC, DONE);
  - N_W and D_W defaults;
  - counter width localparam $clog2(N_W);
  - the QUOT_DZ constant for the divide-by-zero quotient.
- Sub-module div_step: purely combinational single restoring step. Inputs: partial remainder, incoming dividend bit, divisor. Outputs: next remainder, quotient bit. The top instantiates it once and holds the FSM, counter and registers.

## Test plan
- Reset, then dividend=1000, divisor=7, start -> done 16 cycles after accept; quotient=142, remainder=6, div_by_zero=0.
- Dividend=65535, divisor=255 -> quotient=257, remainder=0; then dividend=5, divisor=10 -> quotient=0, remainder=5.
- Dividend=1234, divisor=0 -> done 1 cycle after accept; quotient=16'hFFFF, remainder=0, div_by_zero=1; the next normal divide clears the flag.
- Pulse start with other operands 5 cycles into a busy operation -> ignored; the original result is returned; exactly one done pulse.
- Start asserted continuously with new operands each done cycle -> one result every 17 cycles, each correct. Include a reference-model sweep over random operands and all 256 divisors, with the multiplier check quotient*divisor + remainder == dividend.
- Assert rst low 8 cycles into CALC -> all outputs return to reset values asynchronously; no done pulse; the next operation completes correctly.

Source files
------------

// File: rtl/seq_divider_16x8_pkg.sv
// div_pkg: shared widths, FSM state type and divide-by-zero constant for seq_divider_16x8
package div_pkg;
    localparam int N_W_DEF = 16;
    localparam int D_W_DEF = 8;
    function automatic int cnt_w(input int n);
        return $clog2(n);
    endfunction
    localparam int CNT_W = cnt_w(N_W_DEF);
    localparam logic [N_W_DEF-1:0] QUOT_DZ = '1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/seq_divider_16x8_if.sv
// seq_divider_16x8_if: start/ready/done handshake and operand/result bus
//   master drives start_i, dividend_i, divisor_i; slave drives ready_o, done_o,
//   quotient_o, remainder_o, div_by_zero_o
interface seq_divider_16x8_if import div_pkg::*; #(
    parameter int N_W = N_W_DEF,
    parameter int D_W = D_W_DEF
) ();
    logic           start_i;
    logic [N_W-1:0] dividend_i;
    logic [D_W-1:0] divisor_i;
    logic           ready_o;
    logic           done_o;
    logic [N_W-1:0] quotient_o;
    logic [D_W-1:0] remainder_o;
    logic           div_by_zero_o;
    modport master (
        output start_i, dividend_i, divisor_i,
        input  ready_o, done_o, quotient_o, remainder_o, div_by_zero_o
    );
    modport slave (
        input  start_i, dividend_i, divisor_i,
        output ready_o, done_o, quotient_o, remainder_o, div_by_zero_o
    );
endinterface

// File: rtl/seq_divider_16x8_step.sv
// div_step: one combinational restoring-division step
//   rem_i partial remainder, bit_i next dividend bit, dvs_i divisor
//   rem_o next partial remainder, q_o quotient bit
module div_step #(
    parameter int D_W = 8
) (
    input  logic [D_W:0]   rem_i,
    input  logic           bit_i,
    input  logic [D_W-1:0] dvs_i,
    output logic [D_W:0]   rem_o,
    output logic           q_o
);
    logic [D_W+1:0] sh;
    // The remainder top bit is always 0, so shifting the full word equals
    // shifting the low D_W bits while keeping every input bit in use.
    always_comb begin
        sh    = {rem_i, bit_i};
        q_o   = sh >= {2'b00, dvs_i};
        rem_o = q_o ? (D_W+1)'(sh - {2'b00, dvs_i}) : sh[D_W:0];
    end
endmodule

// File: rtl/seq_divider_16x8.sv
// seq_divider_16x8: sequential 16/8 unsigned restoring divider with start/ready/done
//   clk, rst_n (async active-low); bus (slave): operands in, results/handshake out
module seq_divider_16x8 import div_pkg::*; #(
    parameter int N_W = N_W_DEF,
    parameter int D_W = D_W_DEF
) (
    input logic               clk,
    input logic               rst_n,
    seq_divider_16x8_if.slave bus
);
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N_W-1:0]   shf_q, quot_q, shf_d;
    logic [D_W:0]     rem_q, rem_d;
    logic [D_W-1:0]   dvs_q, res_r_q;
    logic             ready_q, done_q, dz_q, dzp_q, qb_d, acc;
    assign acc   = bus.start_i && ready_q;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    assign shf_d = {shf_q[N_W-2:0], qb_d};
    div_step #(.D_W(D_W)) u_step (
        .rem_i (rem_q),
        .bit_i (shf_q[N_W-1]),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .q_o   (qb_d)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shf_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            res_r_q <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            dzp_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (acc) begin
                shf_q   <= bus.dividend_i;
                rem_q   <= '0;
                dvs_q   <= bus.divisor_i;
                cnt_q   <= '0;
                quot_q  <= '0;
                res_r_q <= '0;
                dz_q    <= 1'b0;
                // A zero divisor skips CALC; its result is posted one cycle later.
                dzp_q   <= bus.divisor_i == '0;
                ready_q <= bus.divisor_i == '0;
                state_q <= bus.divisor_i == '0 ? DONE : CALC;
            end else if (dzp_q) begin
                dzp_q  <= 1'b0;
                done_q <= 1'b1;
                quot_q <= N_W'(QUOT_DZ);
                dz_q   <= 1'b1;
            end else if (state_q == CALC) begin
                shf_q <= shf_d;
                rem_q <= rem_d;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N_W-1)) begin
                    state_q <= DONE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b1;
                    quot_q  <= shf_d;
                    res_r_q <= rem_d[D_W-1:0];
                end
            end
        end
    end
    assign bus.ready_o       = ready_q;
    assign bus.done_o        = done_q;
    assign bus.quotient_o    = quot_q;
    assign bus.remainder_o   = res_r_q;
    assign bus.div_by_zero_o = dz_q;
endmodule

// File: tb/tb_seq_divider_16x8.sv
// tb_seq_divider_16x8: randomized and directed checks of seq_divider_16x8 against a cycle-level reference model
module tb_seq_divider_16x8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    seq_divider_16x8_if bus ();
    seq_divider_16x8 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    logic        e_ready = 1'b1, e_done = 1'b0, e_dz = 1'b0, p_z = 1'b0;
    logic [15:0] e_q = '0, p_q = '0, m_dd = '0;
    logic [7:0]  e_r = '0, p_r = '0, m_dv = '0;
    int          cyc = 0, due = -1;
    task automatic chk(input string n, input int a, input int b);
        checks++;
        if (a != b) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, b, $time);
        end
    endtask
    // Reference: results from plain / and %, timing from accept-edge arithmetic.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            e_ready = 1'b1; e_done = 1'b0; e_q = '0; e_r = '0; e_dz = 1'b0;
            due = -1; cyc = 0;
        end else begin
            e_done = 1'b0;
            if (e_ready && bus.start_i) begin
                m_dd = bus.dividend_i;
                m_dv = bus.divisor_i;
                p_z  = m_dv == 0;
                p_q  = p_z ? 16'hFFFF : m_dd / 16'(m_dv);
                p_r  = p_z ? 8'd0 : 8'(m_dd % 16'(m_dv));
                e_q = '0; e_r = '0; e_dz = 1'b0;
                due = cyc + (p_z ? 1 : 16);
                e_ready = p_z;
            end else if (cyc == due) begin
                e_done = 1'b1; e_ready = 1'b1;
                e_q = p_q; e_r = p_r; e_dz = p_z;
                due = -1;
            end
            cyc++;
        end
    end
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("ready", int'(bus.ready_o), int'(e_ready));
            chk("done", int'(bus.done_o), int'(e_done));
            if (e_ready) begin
                chk("quotient", int'(bus.quotient_o), int'(e_q));
                chk("remainder", int'(bus.remainder_o), int'(e_r));
                chk("div_by_zero", int'(bus.div_by_zero_o), int'(e_dz));
            end
            if (e_done && !e_dz) begin
                chk("q*d+r", int'(bus.quotient_o) * int'(m_dv) + int'(bus.remainder_o), int'(m_dd));
                chk("r<d", int'(bus.remainder_o < m_dv), 1);
            end
        end
    end
    task automatic op(input logic [15:0] dd, input logic [7:0] dv, input logic [15:0] xq,
                      input logic [7:0] xr, input logic xz, input int xlat, input int poke);
        int k;
        bit seen;
        @(negedge clk);
        bus.start_i = 1'b1; bus.dividend_i = dd; bus.divisor_i = dv;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        k = 0; seen = 0;
        while (k < 40 && !seen) begin
            @(negedge clk);
            if (bus.done_o) seen = 1;
            else begin
                @(posedge clk);
                k++;
                if (k == poke) begin
                    #1 bus.start_i = 1'b1; bus.dividend_i = 16'd777; bus.divisor_i = 8'd9;
                end else if (poke > 0 && k == poke + 1) begin
                    #1 bus.start_i = 1'b0;
                end
            end
        end
        chk("done_seen", int'(seen), 1);
        if (xlat >= 0) begin
            chk("latency", k, xlat);
            chk("lit_quotient", int'(bus.quotient_o), int'(xq));
            chk("lit_remainder", int'(bus.remainder_o), int'(xr));
            chk("lit_div_by_zero", int'(bus.div_by_zero_o), int'(xz));
        end
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int k;
        bus.start_i = 1'b0; bus.dividend_i = '0; bus.divisor_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(bus.ready_o), 1);
        chk("rst_done", int'(bus.done_o), 0);
        chk("rst_quotient", int'(bus.quotient_o), 0);
        chk("rst_remainder", int'(bus.remainder_o), 0);
        chk("rst_div_by_zero", int'(bus.div_by_zero_o), 0);
        op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16, 0);
        op(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 16, 0);
        op(16'd5, 8'd10, 16'd0, 8'd5, 1'b0, 16, 0);
        op(16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1, 1, 0);
        op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16, 0);
        op(16'd50000, 8'd3, 16'd16666, 8'd2, 1'b0, 16, 5);
        bus.start_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.dividend_i = 16'($urandom);
            bus.divisor_i = 8'($urandom_range(255, 1));
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!bus.ready_o && k < 40);
            if (i > 0) chk("b2b_gap", k, 17);
            @(posedge clk);
            #1;
        end
        bus.start_i = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.done_o && k < 40);
        chk("b2b_last_done", int'(bus.done_o), 1);
        for (int d = 0; d < 256; d++) op(16'($urandom), 8'(d), '0, '0, 1'b0, -1, 0);
        @(negedge clk);
        bus.start_i = 1'b1; bus.dividend_i = 16'd1000; bus.divisor_i = 8'd7;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ready", int'(bus.ready_o), 1);
        chk("arst_done", int'(bus.done_o), 0);
        chk("arst_quotient", int'(bus.quotient_o), 0);
        chk("arst_remainder", int'(bus.remainder_o), 0);
        chk("arst_div_by_zero", int'(bus.div_by_zero_o), 0);
        repeat (20) begin
            @(negedge clk);
            chk("arst_no_done", int'(bus.done_o), 0);
        end
        rst_n = 1'b1;
        op(16'd40001, 8'd200, 16'd200, 8'd1, 1'b0, 16, 0);
        repeat (20) op(16'($urandom), 8'($urandom), '0, '0, 1'b0, -1, 0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
